// File: rtl/umem_pkg.sv
// rtl/umem_pkg.sv - shared constants and helpers for unified_memory
package umem_pkg;

  localparam int BYTE_W = 8;

  // Supported configuration ranges
  localparam int FETCH_BYTES_MIN = 1;
  localparam int FETCH_BYTES_MAX = 4;
  localparam int RD_LAT_MIN      = 1;
  localparam int RD_LAT_MAX      = 4;

  // Byte address (addr + i) wrapped to a 2**addr_w deep array
  function automatic logic [31:0] wrap_addr(input logic [31:0] addr,
                                            input logic [31:0] i,
                                            input int          addr_w);
    logic [31:0] mask;
    mask = (32'd1 << addr_w) - 32'd1;
    return (addr + i) & mask;
  endfunction

  // Even-parity bit: stored bit makes the 9-bit word have an even count of ones
  function automatic logic parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/umem_rsp_pipe.sv
// rtl/umem_rsp_pipe.sv - fixed-depth valid/data response shift register
module umem_rsp_pipe #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  // Shift valid every cycle; data only advances with a valid beat so the
  // final stage holds the last returned value while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      if (in_valid) data_q[0] <= in_data;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        if (valid_q[k-1]) data_q[k] <= data_q[k-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/unified_memory.sv
// rtl/unified_memory.sv - shared byte array with fetch and data ports (optional parity: UNIFIED_MEMORY_PARITY_EN)
module unified_memory
  import umem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int FETCH_BYTES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          f_req,
  input  logic [ADDR_W-1:0]             f_addr,
  output logic                          f_rvalid,
  output logic [BYTE_W*FETCH_BYTES-1:0] f_instr,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [BYTE_W-1:0]             d_wdata,
  output logic                          d_ready,
  output logic                          d_rvalid,
  output logic [BYTE_W-1:0]             d_rdata
`ifdef UNIFIED_MEMORY_PARITY_EN
  ,
  output logic                          f_perr,
  output logic                          d_perr
`endif
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int FINST_W = BYTE_W * FETCH_BYTES;

  logic [BYTE_W-1:0] mem_data [DEPTH];

  logic ready_q;
  logic d_rd;
  logic d_wr;

  assign d_ready = ready_q;
  assign d_rd    = d_req & ~d_we & ready_q;
  assign d_wr    = d_req &  d_we & ready_q;

  // Data port opens one full cycle after reset is released
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Byte array write; reads below sample the pre-edge contents
  always_ff @(posedge clk) begin
    if (d_wr) mem_data[d_addr] <= d_wdata;
  end

  logic [FINST_W-1:0] f_raw;
  logic [BYTE_W-1:0]  d_raw;

`ifdef UNIFIED_MEMORY_PARITY_EN
  logic                   mem_par [DEPTH];
  logic [FETCH_BYTES-1:0] f_par_raw;
  logic                   d_par_raw;

  // Parity bit stored alongside every written byte
  always_ff @(posedge clk) begin
    if (d_wr) mem_par[d_addr] <= parity(d_wdata);
  end
`endif

  // Gather the fetch bytes big-endian, wrapping past the top of the array
  always_comb begin
    logic [ADDR_W-1:0] idx;
    f_raw = '0;
    idx   = '0;
`ifdef UNIFIED_MEMORY_PARITY_EN
    f_par_raw = '0;
`endif
    for (int i = 0; i < FETCH_BYTES; i++) begin
      idx = ADDR_W'(wrap_addr(32'(f_addr), 32'(i), ADDR_W));
      f_raw[BYTE_W*(FETCH_BYTES-i)-1 -: BYTE_W] = mem_data[idx];
`ifdef UNIFIED_MEMORY_PARITY_EN
      f_par_raw[FETCH_BYTES-1-i] = mem_par[idx];
`endif
    end
  end

  assign d_raw = mem_data[d_addr];

`ifdef UNIFIED_MEMORY_PARITY_EN
  assign d_par_raw = mem_par[d_addr];

  logic [FINST_W+FETCH_BYTES-1:0] f_pipe_out;
  logic [BYTE_W:0]                d_pipe_out;
  logic [FETCH_BYTES-1:0]         f_bad;

  umem_rsp_pipe #(.DATA_W(FINST_W + FETCH_BYTES), .DEPTH(RD_LAT)) u_f_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (f_req),
    .in_data   ({f_par_raw, f_raw}),
    .out_valid (f_rvalid),
    .out_data  (f_pipe_out)
  );

  umem_rsp_pipe #(.DATA_W(BYTE_W + 1), .DEPTH(RD_LAT)) u_d_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_rd),
    .in_data   ({d_par_raw, d_raw}),
    .out_valid (d_rvalid),
    .out_data  (d_pipe_out)
  );

  assign f_instr = f_pipe_out[FINST_W-1:0];
  assign d_rdata = d_pipe_out[BYTE_W-1:0];

  // Recheck each returned byte against its stored parity bit
  always_comb begin
    f_bad = '0;
    for (int j = 0; j < FETCH_BYTES; j++) begin
      f_bad[j] = parity(f_pipe_out[BYTE_W*j +: BYTE_W]) ^ f_pipe_out[FINST_W+j];
    end
  end

  assign f_perr = f_rvalid & (|f_bad);
  assign d_perr = d_rvalid & (parity(d_pipe_out[BYTE_W-1:0]) ^ d_pipe_out[BYTE_W]);
`else
  umem_rsp_pipe #(.DATA_W(FINST_W), .DEPTH(RD_LAT)) u_f_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (f_req),
    .in_data   (f_raw),
    .out_valid (f_rvalid),
    .out_data  (f_instr)
  );

  umem_rsp_pipe #(.DATA_W(BYTE_W), .DEPTH(RD_LAT)) u_d_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_rd),
    .in_data   (d_raw),
    .out_valid (d_rvalid),
    .out_data  (d_rdata)
  );
`endif

endmodule

// File: tb/tb_unified_memory.sv
// tb/tb_unified_memory.sv - directed bench for unified_memory at RD_LAT 1 and 3
module tb_unified_memory;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [7:0]  f_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [7:0]  d_wdata = '0;

  logic        a_f_rvalid, b_f_rvalid;
  logic [15:0] a_f_instr, b_f_instr;
  logic        a_d_ready, b_d_ready;
  logic        a_d_rvalid, b_d_rvalid;
  logic [7:0]  a_d_rdata, b_d_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  unified_memory #(.ADDR_W(8), .FETCH_BYTES(2), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rvalid(a_f_rvalid), .f_instr(a_f_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(a_d_ready), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata)
  );

  unified_memory #(.ADDR_W(8), .FETCH_BYTES(2), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rvalid(b_f_rvalid), .f_instr(b_f_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
    tick();
    d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_a_f_rvalid", a_f_rvalid, 0);
    chk("rst_a_d_rvalid", a_d_rvalid, 0);
    chk("rst_a_d_ready",  a_d_ready, 0);
    chk("rst_a_f_instr",  a_f_instr, 0);
    chk("rst_a_d_rdata",  a_d_rdata, 0);
    chk("rst_b_d_ready",  b_d_ready, 0);
    tick();
    rst = 1'b0;
    chk("ready_low_after_rst", a_d_ready, 0);
    tick();
    chk("ready_high_a", a_d_ready, 1);
    chk("ready_high_b", b_d_ready, 1);

    // write then read-after-write
    wr(8'h10, 8'hA5);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
    tick();
    d_req = 1'b0;
    chk("raw_a_valid", a_d_rvalid, 1);
    chk("raw_a_data",  a_d_rdata, 8'hA5);
    chk("raw_b_early", b_d_rvalid, 0);
    tick();
    chk("raw_a_idle_valid", a_d_rvalid, 0);
    chk("raw_a_hold",       a_d_rdata, 8'hA5);
    chk("raw_b_early2",     b_d_rvalid, 0);
    tick();
    chk("raw_b_valid", b_d_rvalid, 1);
    chk("raw_b_data",  b_d_rdata, 8'hA5);
    tick();
    chk("raw_b_idle", b_d_rvalid, 0);

    // fetch wrap-around
    wr(8'hFF, 8'h12);
    wr(8'h00, 8'h34);
    f_req = 1'b1; f_addr = 8'hFF;
    tick();
    f_req = 1'b0;
    chk("wrap_a_valid", a_f_rvalid, 1);
    chk("wrap_a_instr", a_f_instr, 16'h1234);
    tick();
    chk("wrap_a_idle", a_f_rvalid, 0);
    chk("wrap_a_hold", a_f_instr, 16'h1234);
    chk("wrap_b_early", b_f_rvalid, 0);
    tick();
    chk("wrap_b_valid", b_f_rvalid, 1);
    chk("wrap_b_instr", b_f_instr, 16'h1234);

    // same-edge write/fetch collision: fetch sees old byte
    wr(8'h1F, 8'h00);
    wr(8'h20, 8'h11);
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h77;
    f_req = 1'b1; f_addr = 8'h1F;
    tick();
    d_req = 1'b0; d_we = 1'b0;
    chk("coll_a_valid", a_f_rvalid, 1);
    chk("coll_a_old",   a_f_instr, 16'h0011);
    tick();
    f_req = 1'b0;
    chk("coll_a_new", a_f_instr, 16'h0077);
    tick();
    chk("coll_b_old_valid", b_f_rvalid, 1);
    chk("coll_b_old",       b_f_instr, 16'h0011);
    tick();
    chk("coll_b_new_valid", b_f_rvalid, 1);
    chk("coll_b_new",       b_f_instr, 16'h0077);

    // back-to-back reads, latency 1 and 3
    wr(8'h01, 8'hC1);
    wr(8'h02, 8'hC2);
    wr(8'h03, 8'hC3);
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01;
    tick();
    chk("b2b_a1", a_d_rdata, 8'hC1);
    chk("b2b_b_wait1", b_d_rvalid, 0);
    d_addr = 8'h02;
    tick();
    chk("b2b_a2", a_d_rdata, 8'hC2);
    chk("b2b_b_wait2", b_d_rvalid, 0);
    d_addr = 8'h03;
    tick();
    d_req = 1'b0;
    chk("b2b_a3_valid", a_d_rvalid, 1);
    chk("b2b_a3", a_d_rdata, 8'hC3);
    chk("b2b_b1_valid", b_d_rvalid, 1);
    chk("b2b_b1", b_d_rdata, 8'hC1);
    tick();
    chk("b2b_a_done", a_d_rvalid, 0);
    chk("b2b_b2_valid", b_d_rvalid, 1);
    chk("b2b_b2", b_d_rdata, 8'hC2);
    tick();
    chk("b2b_b3_valid", b_d_rvalid, 1);
    chk("b2b_b3", b_d_rdata, 8'hC3);
    tick();
    chk("b2b_b_done", b_d_rvalid, 0);
    chk("b2b_b_hold", b_d_rdata, 8'hC3);

    // reset with reads in flight
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01;
    tick();
    d_addr = 8'h02;
    tick();
    d_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_a_valid", a_d_rvalid, 0);
    chk("mrst_b_valid", b_d_rvalid, 0);
    chk("mrst_b_ready", b_d_ready, 0);
    chk("mrst_b_rdata", b_d_rdata, 0);
    tick();
    chk("mrst_b_valid2", b_d_rvalid, 0);
    rst = 1'b0;
    chk("mrst_ready_low", a_d_ready, 0);
    // write offered while not ready must be dropped
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 8'hEE;
    tick();
    chk("mrst_ready_high", a_d_ready, 1);
    chk("mrst_b_valid3", b_d_rvalid, 0);
    chk("mrst_a_valid3", a_d_rvalid, 0);
    d_we = 1'b0;
    tick();
    d_req = 1'b0;
    chk("drop_a_valid", a_d_rvalid, 1);
    chk("drop_a_data",  a_d_rdata, 8'hA5);
    chk("drop_b_wait",  b_d_rvalid, 0);
    tick();
    chk("drop_b_wait2", b_d_rvalid, 0);
    tick();
    chk("drop_b_valid", b_d_rvalid, 1);
    chk("drop_b_data",  b_d_rdata, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
